// File: rtl/video_win_gen.sv
// Raster video pattern generator on an AXI4-Stream master: background, colour bars,
// or a ROM-backed image window fed from a small prefetch FIFO.
module video_win_gen #(
    parameter int DATAW      = 32,
    parameter int SCRW       = 1280,
    parameter int SCRH       = 720,
    parameter int WINW       = 300,
    parameter int WINH       = 370,
    parameter int ADDRW      = 17,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [12:0]        win_x,
    input  logic [12:0]        win_y,
    input  logic [23:0]        bg_color,
    output logic [DATAW-1:0]   m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tuser,
    output logic               m_axis_tlast,
    output logic [DATAW/8-1:0] m_axis_tkeep,
    output logic               bram_en_o,
    output logic [ADDRW-1:0]   bram_addr_o,
    input  logic [23:0]        bram_data_i,
    output logic               busy,
    output logic [15:0]        frame_cnt
);
    // state  | meaning
    // S_IDLE | not generating; waits for en
    // S_SOF  | frame start: latch mode/window/background, flush FIFO if entering mode 1
    // S_RUN  | loading pixels into the output register in raster order

    localparam int PTRW  = $clog2(FIFO_DEPTH);
    localparam int CNTW  = PTRW + 1;
    localparam int NPIX  = WINW * WINH;
    localparam int BAR_W = (SCRW / 8 > 0) ? SCRW / 8 : 1;
    localparam logic [12:0] MAX_WX = 13'(SCRW - WINW);
    localparam logic [12:0] MAX_WY = 13'(SCRH - WINH);

    typedef enum logic [1:0] {S_IDLE, S_SOF, S_RUN} state_t;
    state_t state;

    logic [1:0]  mode_l;
    logic [12:0] wx_l, wy_l, x, y;
    logic [23:0] bg_l;
    logic        last_pix_q;

    logic [23:0]     fifo_mem [FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic [CNTW-1:0] fifo_cnt;
    logic            rd_pend;

    logic [1:0]  mode_new;
    logic [12:0] wx_new, wy_new;
    logic [13:0] x14, y14, wx14, wy14;
    logic        in_win, fifo_empty, out_free, load, hs, x_last, y_last;
    logic        stop, switch1, flush, push, pop;
    logic [12:0] bar_q;
    logic [2:0]  bar_idx;
    logic [23:0] bar_color, pix;

    assign mode_new = (mode == 2'd3) ? 2'd0 : mode;
    assign wx_new   = (win_x > MAX_WX) ? MAX_WX : win_x;
    assign wy_new   = (win_y > MAX_WY) ? MAX_WY : win_y;

    assign x14  = {1'b0, x};
    assign y14  = {1'b0, y};
    assign wx14 = {1'b0, wx_l};
    assign wy14 = {1'b0, wy_l};
    assign in_win = (mode_l == 2'd1) && (x14 >= wx14) && (x14 < wx14 + 14'(WINW))
                    && (y14 >= wy14) && (y14 < wy14 + 14'(WINH));

    assign fifo_empty = (fifo_cnt == '0);
    assign out_free   = !m_axis_tvalid || m_axis_tready;
    assign hs         = m_axis_tvalid && m_axis_tready;
    // A window pixel with nothing in the FIFO holds the generator rather than underflowing.
    assign load       = (state == S_RUN) && out_free && !(in_win && fifo_empty);
    assign x_last     = (x == 13'(SCRW - 1));
    assign y_last     = (y == 13'(SCRH - 1));
    assign stop       = load && x_last && y_last && !en;
    assign switch1    = (state == S_SOF) && (mode_new == 2'd1) && (mode_l != 2'd1);
    assign flush      = stop || switch1;
    assign push       = rd_pend;
    assign pop        = load && in_win;

    assign bram_en_o  = (state != S_IDLE) && (mode_l == 2'd1)
                        && ((fifo_cnt + CNTW'(rd_pend)) < CNTW'(FIFO_DEPTH));

    assign bar_q   = x / 13'(BAR_W);
    assign bar_idx = (bar_q > 13'd7) ? 3'd7 : bar_q[2:0];

    always_comb begin
        bar_color = 24'h000000;
        case (bar_idx)
            3'd0: bar_color = 24'hFFFFFF;
            3'd1: bar_color = 24'hFFFF00;
            3'd2: bar_color = 24'h00FFFF;
            3'd3: bar_color = 24'h00FF00;
            3'd4: bar_color = 24'hFF00FF;
            3'd5: bar_color = 24'hFF0000;
            3'd6: bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    end

    always_comb begin
        pix = bg_l;
        case (mode_l)
            2'd1: pix = in_win ? fifo_mem[rd_ptr] : bg_l;
            2'd2: pix = bar_color;
            default: pix = bg_l;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            mode_l        <= 2'd0;
            wx_l          <= '0;
            wy_l          <= '0;
            bg_l          <= '0;
            x             <= '0;
            y             <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            last_pix_q    <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: if (en) begin
                    state <= S_SOF;
                    x     <= '0;
                    y     <= '0;
                end
                S_SOF: begin
                    mode_l <= mode_new;
                    wx_l   <= wx_new;
                    wy_l   <= wy_new;
                    bg_l   <= bg_color;
                    state  <= S_RUN;
                end
                default: ;
            endcase

            if (load) begin
                m_axis_tdata  <= DATAW'(pix);
                m_axis_tvalid <= 1'b1;
                m_axis_tuser  <= (x == '0) && (y == '0);
                m_axis_tlast  <= x_last;
                last_pix_q    <= x_last && y_last;
                if (x_last) begin
                    x <= '0;
                    if (y_last) begin
                        y     <= '0;
                        state <= en ? S_SOF : S_IDLE;
                    end else begin
                        y <= y + 13'd1;
                    end
                end else begin
                    x <= x + 13'd1;
                end
            end else if (hs) begin
                m_axis_tvalid <= 1'b0;
            end

            if (hs && last_pix_q)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Prefetch side: reads issued on bram_en_o land in the FIFO one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            rd_pend     <= 1'b0;
            bram_addr_o <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            rd_pend     <= 1'b0;
            bram_addr_o <= '0;
        end else begin
            rd_pend <= bram_en_o;
            if (bram_en_o)
                bram_addr_o <= (bram_addr_o == ADDRW'(NPIX - 1)) ? '0 : bram_addr_o + ADDRW'(1);
            if (push)
                wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTRW'(1);
            fifo_cnt <= fifo_cnt + CNTW'(push) - CNTW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            fifo_mem[wr_ptr] <= bram_data_i;
    end

    assign m_axis_tkeep = '1;
    assign busy         = (state != S_IDLE) || m_axis_tvalid;

endmodule

// File: doc/video_win_gen.md
VIDEO_WIN_GEN -- requirements
Module: video_win_gen

Interface
REQ-001 SHALL have parameter DATAW, default 32, AXIS tdata width (>=24).
REQ-002 SHALL have parameter SCRW, default 1280, active pixels per line.
REQ-003 SHALL have parameter SCRH, default 720, active lines per frame.
REQ-004 SHALL have parameter WINW, default 300, image window width in pixels.
REQ-005 SHALL have parameter WINH, default 370, image window height in lines.
REQ-006 SHALL have parameter ADDRW, default 17, image ROM address width (2^ADDRW >= WINW*WINH).
REQ-007 SHALL have parameter FIFO_DEPTH, default 16, prefetch FIFO depth (power of 2, >=4).
REQ-008 SHALL have one clock and one reset: clk input 1 system/pixel clock; rst input 1 asynchronous active-high reset.
REQ-009 SHALL have ports: en in 1 stream enable; mode in 2 (0 background, 1 window image, 2 colour bars, 3 = 0); win_x in 13, win_y in 13 window top-left; bg_color in 24.
REQ-010 SHALL have ports: m_axis_tdata out DATAW; m_axis_tvalid out 1; m_axis_tready in 1; m_axis_tuser out 1 (SOF); m_axis_tlast out 1 (EOL); m_axis_tkeep out DATAW/8 (all ones).
REQ-011 SHALL have ports: bram_en_o out 1; bram_addr_o out ADDRW; bram_data_i in 24; busy out 1; frame_cnt out 16.

Function
REQ-012 SHALL generate pixels in raster order into a single output register stage; the register loads when empty or when the current beat handshakes (tvalid && tready).
REQ-013 SHALL hold tdata/tuser/tlast stable while tvalid=1 and tready=0; tvalid SHALL never drop without a handshake.
REQ-014 SHALL advance generator counters x (0..SCRW-1) and y (0..SCRH-1) only on output-register load; x wraps to 0 and increments y; y wraps to 0 after (SCRW-1, SCRH-1).
REQ-015 SHALL set tuser=1 only for pixel (0,0) and tlast=1 only for x=SCRW-1; tdata[23:0]=pixel, upper bits 0.
REQ-016 SHALL latch mode, win_x, win_y, bg_color at each frame start (loading pixel (0,0)); mid-frame changes take effect next frame.
REQ-017 SHALL clamp latched win_x to SCRW-WINW and win_y to SCRH-WINH when exceeded.
REQ-018 SHALL define window pixel as win_x<=x<win_x+WINW and win_y<=y<win_y+WINH, compared in 14-bit arithmetic.
REQ-019 Mode 0: every pixel = bg_color. Mode 2: 8 equal vertical bars of width SCRW/8 (last bar absorbs remainder), colours white, yellow, cyan, green, magenta, red, blue, black (24'hFFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000).
REQ-020 Mode 1: window pixels popped from prefetch FIFO (first-word-fall-through head), others bg_color.
REQ-021 SHALL stall loading (tvalid falls only after the pending beat handshakes) when the next pixel is a window pixel and the FIFO is empty; no underflow, no pixel reordering.
REQ-022 Prefetch: assert bram_en_o when FIFO occupancy + in-flight reads < FIFO_DEPTH and latched mode=1; bram_data_i valid exactly one cycle after bram_en_o; write it to FIFO then.
REQ-023 SHALL increment bram_addr_o per read, wrapping from WINW*WINH-1 to 0 (continuous prefetch across frames).
REQ-024 SHALL flush FIFO, discard in-flight data and reset bram_addr_o to 0 when latched mode changes to 1 at frame start, and when streaming stops.
REQ-025 en rising while idle: start streaming at pixel (0,0) next cycle; busy=1.
REQ-026 en low while streaming: finish the current frame; stop after last-pixel handshake; busy=0 when output register empties.
REQ-027 SHALL increment frame_cnt (wrapping at 16'hFFFF) on handshake of pixel (SCRW-1, SCRH-1).

Reset
REQ-028 On rst: tvalid, tuser, tlast, tdata, bram_en_o, bram_addr_o, busy, frame_cnt, x, y = 0; FIFO empty; latched mode=0.
REQ-029 Reset asserted mid-frame SHALL abort immediately (tvalid=0 asynchronously); streaming restarts at (0,0) only after release with en=1.

Verification (SCRW=16, SCRH=8, WINW=4, WINH=3, FIFO_DEPTH=4)
REQ-030 mode=0, bg=24'h010101, tready=1 -> 128 beats of 010101, tuser on beat 0, tlast every 16th, frame_cnt=1.
REQ-031 mode=1, win=(5,2), ROM data=addr -> beats at (5..8,2..4) carry 0..11 in order, rest bg; frame 2 repeats 0..11.
REQ-032 mode=1, random tready 50%, ROM data=addr -> same data sequence as REQ-031; tdata stable under backpressure.
REQ-033 win_x=20 -> window clamped to x=12..15; mode=2 -> bars 2 pixels wide, FFFFFF first, 000000 last.
REQ-034 en dropped at beat 40 -> frame completes (128 beats), busy falls; rst at beat 60 -> tvalid=0, bram_addr_o=0 immediately.
